// File: rtl/pic24_icsp_engine.sv
// PIC24 ICSP/EICSP host engine: turns ENTER/SIX/REGOUT/EXIT ops into
// MCLRn/PGC/PGD pin sequences with parameterised timing.
module pic24_icsp_engine #(
  parameter int          CLK_DIV   = 2,
  parameter int          P6_CLKS   = 6,
  parameter int          P18_CLKS  = 2,
  parameter int          P19_CLKS  = 1000,
  parameter int          P7_CLKS   = 1000,
  parameter int          P4_CLKS   = 2,
  parameter int          P5_CLKS   = 1,
  parameter int          EXIT_CLKS = 8,
  parameter logic [31:0] ICSP_KEY  = 32'h4D434851,
  parameter logic [31:0] EICSP_KEY = 32'h4D434850
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op,
  input  logic [23:0] op_data,
  input  logic        enh_mode,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        err,
  output logic        session,
  output logic        PGCx,
  input  logic        PGDx_in,
  output logic        PGDx_out,
  output logic        PGDx_dir,
  output logic        MCLRn
);
  typedef enum logic [3:0] {
    OFF, ENT_PULSE, ENT_LOW, ENT_KEY, ENT_P19, ENT_P7, ENT_PAD, ACTIVE,
    SIX_SH, RO_CMD, RO_IDLE, RO_P5, RO_DATA, GAP, EXIT_HOLD
  } state_e;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXD = max2(
    max2(max2(P6_CLKS, P18_CLKS), max2(P19_CLKS, P7_CLKS)),
    max2(max2(P4_CLKS, P5_CLKS), max2(EXIT_CLKS, 2*CLK_DIV)));
  localparam int CW = $clog2(MAXD + 1);

  function automatic logic is_cell(state_e s);
    return s inside {ENT_KEY, ENT_PAD, SIX_SH, RO_CMD, RO_IDLE, RO_DATA};
  endfunction

  function automatic int n_cells(state_e s);
    case (s)
      ENT_KEY: return 32;
      ENT_PAD: return 9;
      SIX_SH:  return 28;
      RO_CMD:  return 4;
      RO_IDLE: return 8;
      RO_DATA: return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int dly_len(state_e s);
    case (s)
      ENT_PULSE: return P6_CLKS;
      ENT_LOW:   return P18_CLKS;
      ENT_P19:   return P19_CLKS;
      ENT_P7:    return P7_CLKS;
      RO_P5:     return P5_CLKS;
      GAP:       return P4_CLKS;
      EXIT_HOLD: return EXIT_CLKS;
      default:   return 2*CLK_DIV;
    endcase
  endfunction

  function automatic state_e nxt(state_e s);
    case (s)
      ENT_PULSE: return ENT_LOW;
      ENT_LOW:   return ENT_KEY;
      ENT_KEY:   return ENT_P19;
      ENT_P19:   return ENT_P7;
      ENT_P7:    return ENT_PAD;
      ENT_PAD:   return ACTIVE;
      SIX_SH:    return GAP;
      RO_CMD:    return RO_IDLE;
      RO_IDLE:   return RO_P5;
      RO_P5:     return RO_DATA;
      RO_DATA:   return GAP;
      GAP:       return ACTIVE;
      EXIT_HOLD: return OFF;
      default:   return s;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_q, bit_d;
  logic [27:0]   sh_q, sh_d;
  logic [31:0]   key_q, key_d;
  logic [15:0]   rx_q, rx_d;
  logic [15:0]   rsp_q, rsp_d;
  logic          rdy_q, rdy_d, rspv_q, rspv_d, err_q, err_d;
  logic          sess_q, sess_d, dir_q, dir_d;
  logic          pgc_q, pgc_d, pgd_q, pgd_d, mclr_q, mclr_d;
  logic          legal, cell_end, last;

  assign legal = (op == 2'b11) ||
                 ((op == 2'b10) ? !sess_q : sess_q);
  assign cell_end = int'(cnt_q) == 2*CLK_DIV - 1;
  assign last = is_cell(state_q)
    ? (cell_end && int'(bit_q) == n_cells(state_q) - 1)
    : (int'(cnt_q) == dly_len(state_q) - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    key_d   = key_q;
    rx_d    = rx_q;
    rsp_d   = rsp_q;
    rdy_d   = rdy_q;
    sess_d  = sess_q;
    dir_d   = dir_q;
    rspv_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == OFF || state_q == ACTIVE) begin
      cnt_d = '0;
      bit_d = '0;
      if (op_valid && rdy_q) begin
        if (!legal) begin
          err_d = 1'b1;
        end else begin
          rdy_d = 1'b0;
          unique case (op)
            2'b00: begin
              sh_d    = {op_data, 4'b0000};
              state_d = SIX_SH;
            end
            2'b01: begin
              sh_d    = 28'd1;
              state_d = RO_CMD;
            end
            2'b10: begin
              key_d   = enh_mode ? EICSP_KEY : ICSP_KEY;
              state_d = ENT_PULSE;
            end
            default: begin
              sess_d  = 1'b0;
              state_d = EXIT_HOLD;
            end
          endcase
        end
      end
    end else begin
      if (is_cell(state_q) && cell_end) begin
        cnt_d = '0;
        bit_d = bit_q + 6'd1;
        sh_d  = {1'b0, sh_q[27:1]};
        key_d = {key_q[30:0], 1'b0};
        if (state_q == RO_DATA) rx_d = {PGDx_in, rx_q[15:1]};
      end
      if (last) begin
        state_d = nxt(state_q);
        cnt_d   = '0;
        bit_d   = '0;
        unique case (state_q)
          ENT_PAD: begin
            sess_d = 1'b1;
            rdy_d  = 1'b1;
          end
          RO_IDLE: dir_d = 1'b1;
          RO_DATA: begin
            rsp_d  = rx_d;
            rspv_d = 1'b1;
          end
          GAP: begin
            dir_d = 1'b0;
            rdy_d = 1'b1;
          end
          EXIT_HOLD: rdy_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Pin levels follow the next state so PGD moves only at a cell start.
  assign pgc_d  = is_cell(state_d) && int'(cnt_d) >= CLK_DIV;
  assign mclr_d = !(state_d inside {OFF, ENT_LOW, ENT_KEY, ENT_P19, EXIT_HOLD});

  always_comb begin
    pgd_d = 1'b0;
    if (!dir_d) begin
      if (state_d == ENT_KEY) pgd_d = key_d[31];
      else if (state_d inside {SIX_SH, RO_CMD, RO_IDLE}) pgd_d = sh_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= OFF;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      key_q   <= '0;
      rx_q    <= '0;
      rsp_q   <= '0;
      rdy_q   <= 1'b1;
      rspv_q  <= 1'b0;
      err_q   <= 1'b0;
      sess_q  <= 1'b0;
      dir_q   <= 1'b0;
      pgc_q   <= 1'b0;
      pgd_q   <= 1'b0;
      mclr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      key_q   <= key_d;
      rx_q    <= rx_d;
      rsp_q   <= rsp_d;
      rdy_q   <= rdy_d;
      rspv_q  <= rspv_d;
      err_q   <= err_d;
      sess_q  <= sess_d;
      dir_q   <= dir_d;
      pgc_q   <= pgc_d;
      pgd_q   <= pgd_d;
      mclr_q  <= mclr_d;
    end
  end

  assign op_ready  = rdy_q;
  assign rsp_valid = rspv_q;
  assign rsp_data  = rsp_q;
  assign err       = err_q;
  assign session   = sess_q;
  assign PGCx      = pgc_q;
  assign PGDx_out  = pgd_q;
  assign PGDx_dir  = dir_q;
  assign MCLRn     = mclr_q;
endmodule

// File: tb/tb_pic24_icsp_engine.sv
// Bench for pic24_icsp_engine: op vector table with expected-result queue,
// plus a reset-during-SIX sequence.
module tb_pic24_icsp_engine;
  localparam int CD  = 1;
  localparam int P6  = 6;
  localparam int P18 = 2;
  localparam int P19 = 4;
  localparam int P7  = 4;
  localparam int P4  = 2;
  localparam int P5  = 1;
  localparam int EXC = 8;
  localparam logic [31:0] KEY_I = 32'h4D434851;
  localparam logic [31:0] KEY_E = 32'h4D434850;
  localparam int SIXB = 28*2*CD + P4;
  localparam int ROB  = 28*2*CD + P5 + P4;
  localparam int ROR  = 1 + 28*2*CD + P5;
  localparam int ENB  = P6 + P18 + 32*2*CD + P19 + P7 + 9*2*CD;
  localparam int ROD  = P5 + 16*2*CD + P4;
  localparam int NV   = 13;

  typedef struct {
    logic [1:0]  op;
    logic [23:0] data;
    logic        enh;
    logic [15:0] tgt;
    int          busy;
    logic        er;
    logic        sess;
    int          nbits;
    logic [63:0] bits;
    int          mrun;
    int          dirc;
    int          rspn;
    logic [15:0] rsp;
  } vec_t;

  logic        clk, rstn, op_valid, op_ready, enh_mode;
  logic [1:0]  op;
  logic [23:0] op_data;
  logic        rsp_valid, err, session;
  logic [15:0] rsp_data;
  logic        PGCx, PGDx_in, PGDx_out, PGDx_dir, MCLRn;

  int   n_cmp, n_bad;
  vec_t vecs[NV];
  vec_t exp_q[$];

  pic24_icsp_engine #(
    .CLK_DIV(CD), .P6_CLKS(P6), .P18_CLKS(P18), .P19_CLKS(P19),
    .P7_CLKS(P7), .P4_CLKS(P4), .P5_CLKS(P5), .EXIT_CLKS(EXC),
    .ICSP_KEY(KEY_I), .EICSP_KEY(KEY_E)
  ) dut (
    .clk(clk), .rstn(rstn), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .op_data(op_data), .enh_mode(enh_mode),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
    .session(session), .PGCx(PGCx), .PGDx_in(PGDx_in),
    .PGDx_out(PGDx_out), .PGDx_dir(PGDx_dir), .MCLRn(MCLRn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rev32(input logic [31:0] k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = k[31-i];
    return r;
  endfunction

  function automatic vec_t mk(
    input logic [1:0] o, input logic [23:0] d, input logic en,
    input logic [15:0] t, input int busy, input logic er, input logic ss,
    input int nb, input logic [63:0] b, input int mr, input int dc,
    input int rn, input logic [15:0] r);
    vec_t v;
    v.op = o; v.data = d; v.enh = en; v.tgt = t; v.busy = busy;
    v.er = er; v.sess = ss; v.nbits = nb; v.bits = b; v.mrun = mr;
    v.dirc = dc; v.rspn = rn; v.rsp = r;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ready"}, 64'(op_ready), 64'd1);
    chk({nm, "_pgc"},   64'(PGCx), 64'd0);
    chk({nm, "_mclr"},  64'(MCLRn), 64'd0);
    chk({nm, "_sess"},  64'(session), 64'd0);
    chk({nm, "_rsp"},   64'(rsp_data), 64'd0);
    chk({nm, "_dir"},   64'(PGDx_dir), 64'd0);
    chk({nm, "_pgd"},   64'(PGDx_out), 64'd0);
    chk({nm, "_flags"}, 64'({err, rsp_valid}), 64'd0);
  endtask

  task automatic run_op(input int idx, input vec_t v);
    vec_t        e;
    int          n, nb, mrun, dirc, viol, errc, rspc, rspn;
    logic [63:0] bits;
    logic        pp, pd, mon, done;
    logic [3:0]  ti;
    string       p;
    p = $sformatf("v%0d", idx);
    exp_q.push_back(v);
    n = 0; nb = 0; mrun = 0; dirc = 0; viol = 0; errc = 0;
    rspc = 0; rspn = 0; bits = '0; mon = 1'b1; done = 1'b0; ti = '0;
    chk({p, "_acc_ready"}, 64'(op_ready), 64'd1);
    op = v.op; op_data = v.data; enh_mode = v.enh; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op_data = ~v.data; enh_mode = ~v.enh;
    pp = PGCx; pd = PGDx_out;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (PGDx_dir && PGCx) begin
        PGDx_in = v.tgt[ti];
        ti++;
      end else begin
        PGDx_in = 1'($urandom_range(0, 1));
      end
      if (PGCx && !pp && nb < 64) begin
        bits[nb] = PGDx_out;
        nb++;
      end
      if (PGCx && pp && PGDx_out != pd) viol++;
      if (PGDx_dir && PGDx_out) viol++;
      if (err && rsp_valid) viol++;
      if (PGDx_dir) dirc++;
      if (mon && MCLRn) mrun++;
      else mon = 1'b0;
      if (err) errc++;
      if (rsp_valid) begin
        rspc++;
        if (rspn == 0) rspn = n;
      end
      pp = PGCx; pd = PGDx_out;
      if (op_ready) done = 1'b1;
    end
    e = exp_q.pop_front();
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got busy>%0d, want %0d", p, n, e.busy);
    end
    chk({p, "_busy"},  64'(n - 1), 64'(e.busy));
    chk({p, "_err"},   64'(errc), 64'(e.er));
    chk({p, "_sess"},  64'(session), 64'(e.sess));
    chk({p, "_nbits"}, 64'(nb), 64'(e.nbits));
    chk({p, "_bits"},  bits, e.bits);
    chk({p, "_mrun"},  64'(mrun), 64'(e.mrun));
    chk({p, "_dir"},   64'(dirc), 64'(e.dirc));
    chk({p, "_viol"},  64'(viol), 64'd0);
    chk({p, "_rspc"},  64'(rspc), 64'(e.rspn != 0));
    chk({p, "_rspn"},  64'(rspn), 64'(e.rspn));
    chk({p, "_rsp"},   64'(rsp_data), 64'(e.rsp));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rstn = 1'b0; op_valid = 1'b0; op = 2'd0; op_data = 24'h0;
    enh_mode = 1'b0; PGDx_in = 1'b0;
    vecs[0]  = mk(2'd0, 24'h111111, 1'b0, 16'h0, 0, 1'b1, 1'b0,
                  0, 64'h0, 0, 0, 0, 16'h0);
    vecs[1]  = mk(2'd1, 24'h0, 1'b0, 16'hFFFF, 0, 1'b1, 1'b0,
                  0, 64'h0, 0, 0, 0, 16'h0);
    vecs[2]  = mk(2'd3, 24'h0, 1'b0, 16'h0, EXC, 1'b0, 1'b0,
                  0, 64'h0, 0, 0, 0, 16'h0);
    vecs[3]  = mk(2'd2, 24'h0, 1'b1, 16'h0, ENB, 1'b0, 1'b1,
                  41, rev32(KEY_E), P6, 0, 0, 16'h0);
    vecs[4]  = mk(2'd2, 24'h0, 1'b0, 16'h0, 0, 1'b1, 1'b1,
                  0, 64'h0, 1, 0, 0, 16'h0);
    vecs[5]  = mk(2'd0, 24'h040200, 1'b0, 16'h0, SIXB, 1'b0, 1'b1,
                  28, {36'h0, 24'h040200, 4'h0}, SIXB + 1, 0, 0, 16'h0);
    vecs[6]  = mk(2'd1, 24'h0, 1'b0, 16'hA5C3, ROB, 1'b0, 1'b1,
                  28, 64'h1, ROB + 1, ROD, ROR, 16'hA5C3);
    vecs[7]  = mk(2'd0, 24'hABCDEF, 1'b1, 16'h0, SIXB, 1'b0, 1'b1,
                  28, {36'h0, 24'hABCDEF, 4'h0}, SIXB + 1, 0, 0, 16'hA5C3);
    vecs[8]  = mk(2'd1, 24'h0, 1'b0, 16'h5A3C, ROB, 1'b0, 1'b1,
                  28, 64'h1, ROB + 1, ROD, ROR, 16'h5A3C);
    vecs[9]  = mk(2'd3, 24'h0, 1'b0, 16'h0, EXC, 1'b0, 1'b0,
                  0, 64'h0, 0, 0, 0, 16'h5A3C);
    vecs[10] = mk(2'd2, 24'h0, 1'b0, 16'h0, ENB, 1'b0, 1'b1,
                  41, rev32(KEY_I), P6, 0, 0, 16'h5A3C);
    vecs[11] = mk(2'd1, 24'h0, 1'b0, 16'h8001, ROB, 1'b0, 1'b1,
                  28, 64'h1, ROB + 1, ROD, ROR, 16'h8001);
    vecs[12] = mk(2'd0, 24'h123456, 1'b0, 16'h0, SIXB, 1'b0, 1'b1,
                  28, {36'h0, 24'h123456, 4'h0}, SIXB + 1, 0, 0, 16'h8001);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NV; i++) run_op(i, vecs[i]);

    op = 2'd0; op_data = 24'h0F0F0F; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_six_busy", 64'(op_ready), 64'd0);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");
    run_op(100, vecs[3]);
    run_op(101, vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
